// File: rtl/mor1kx_exec_ctrl_fifo_cappuccino.sv
// ---------------------------------------------------------------------------
// mor1kx_exec_ctrl_fifo_cappuccino
//
// Execute-to-control stage buffer for the cappuccino pipeline. A DEPTH-entry
// in-order queue holds instruction records {pc, result, rfd, rf_wb, except,
// op} so that execute can keep retiring while the ctrl stage waits on LSU or
// SPR acknowledges. The block also produces the ctrl->wb register-file write
// registers.
//
// Optional feature: define MOR1KX_EXEC_CTRL_BYPASS_EN to let an incoming
// instruction appear combinationally at the ctrl outputs when the queue is
// empty; if it is consumed in that same cycle it never enters storage.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ex_valid_i/ex_ready_o execute-side handshake
//   ex_*_i                instruction record from execute
//   ctrl_valid_o, ctrl_*  head-of-queue record
//   ctrl_adv_i            ctrl stage consumes the head
//   ctrl_ack_i            LSU/SPR access of the head completed
//   ctrl_ack_data_i       load / mfspr return data
//   wb_*_o                registered RF write strobe, address and data
//   pipeline_flush_i      discard all resident entries
//   du_stall_i            debug stall; suppresses the flush
//   count_o               number of occupied entries
// ---------------------------------------------------------------------------
module mor1kx_exec_ctrl_fifo_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int EXCEPT_WIDTH         = 11,
  parameter int DEPTH                = 2,
  parameter int CNT_WIDTH            = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_valid_i,
  output logic                            ex_ready_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ex_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ex_result_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] ex_rfd_adr_i,
  input  logic                            ex_rf_wb_i,
  input  logic [EXCEPT_WIDTH-1:0]         ex_except_i,
  input  logic [3:0]                      ex_op_i,
  output logic                            ctrl_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_o,
  output logic                            ctrl_rf_wb_o,
  output logic [EXCEPT_WIDTH-1:0]         ctrl_except_o,
  output logic [3:0]                      ctrl_op_o,
  input  logic                            ctrl_adv_i,
  input  logic                            ctrl_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_ack_data_i,
  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  input  logic                            pipeline_flush_i,
  input  logic                            du_stall_i,
  output logic [CNT_WIDTH-1:0]            count_o
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int REC_W = 2*OPTION_OPERAND_WIDTH + OPTION_RF_ADDR_WIDTH + 1 + EXCEPT_WIDTH + 4;
  // op class bit positions: {mtspr, mfspr, store, load}
  localparam int OP_LOAD  = 0;
  localparam int OP_MFSPR = 2;

  logic [REC_W-1:0]     rec_mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CNT_WIDTH-1:0] count_r;

  logic [REC_W-1:0]     ex_rec_s;
  logic [REC_W-1:0]     head_rec_s;
  logic                 empty_s;
  logic                 full_s;
  logic                 long_op_s;
  logic                 head_exc_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 flush_s;
  logic                 bypass_take_s;
  logic                 write_s;
  logic                 read_s;

  assign ex_rec_s = {ex_pc_i, ex_result_i, ex_rfd_adr_i, ex_rf_wb_i, ex_except_i, ex_op_i};
  assign empty_s  = (count_r == {CNT_WIDTH{1'b0}});
  assign full_s   = (count_r == CNT_WIDTH'(DEPTH));

  // Head selection: stored entry, optional pass-through of execute, or zeros.
  always_comb begin
    head_rec_s   = {REC_W{1'b0}};
    ctrl_valid_o = 1'b0;
    if (!empty_s) begin
      head_rec_s   = rec_mem_r[rd_ptr_r];
      ctrl_valid_o = 1'b1;
    end
`ifdef MOR1KX_EXEC_CTRL_BYPASS_EN
    else if (ex_valid_i) begin
      head_rec_s   = ex_rec_s;
      ctrl_valid_o = 1'b1;
    end
`endif
    else begin
      head_rec_s   = {REC_W{1'b0}};
      ctrl_valid_o = 1'b0;
    end
  end

  assign {ctrl_pc_o, ctrl_result_o, ctrl_rfd_adr_o, ctrl_rf_wb_o,
          ctrl_except_o, ctrl_op_o} = head_rec_s;

  // An excepting head never waits for the LSU/SPR ack.
  assign long_op_s  = |ctrl_op_o;
  assign head_exc_s = |ctrl_except_o;
  assign pop_s      = ctrl_valid_o & ctrl_adv_i & (~long_op_s | ctrl_ack_i | head_exc_s);
  assign ex_ready_o = ~full_s | pop_s;
  assign push_s     = ex_valid_i & ex_ready_o;
  assign flush_s    = pipeline_flush_i & ~du_stall_i;

`ifdef MOR1KX_EXEC_CTRL_BYPASS_EN
  // Zero-latency pass-through: consumed before ever being stored. A flush
  // keeps the pushed instruction, so it is stored in that case.
  assign bypass_take_s = empty_s & push_s & pop_s & ~flush_s;
`else
  assign bypass_take_s = 1'b0;
`endif

  assign write_s = push_s & ~bypass_take_s;
  assign read_s  = pop_s & ~bypass_take_s;

  // Record storage; intentionally not reset, validity comes from count_r.
  always_ff @(posedge clk) begin
    if (write_s) begin
      rec_mem_r[wr_ptr_r] <= ex_rec_s;
    end
  end

  // Pointer and occupancy tracking; flush collapses the queue onto the
  // write pointer, keeping a same-cycle push as the only entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_WIDTH{1'b0}};
    end else if (flush_s) begin
      rd_ptr_r <= wr_ptr_r;
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        count_r  <= CNT_WIDTH'(1);
      end else begin
        count_r  <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (read_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({write_s, read_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count_o = count_r;

  // ctrl->wb registers: one-cycle strobe per popped writing instruction;
  // address/data capture on pop and hold otherwise; flush wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= {OPTION_RF_ADDR_WIDTH{1'b0}};
      wb_result_o  <= {OPTION_OPERAND_WIDTH{1'b0}};
    end else if (flush_s) begin
      wb_rf_wb_o   <= 1'b0;
    end else begin
      wb_rf_wb_o <= pop_s & ctrl_rf_wb_o & ~head_exc_s;
      if (pop_s) begin
        wb_rfd_adr_o <= ctrl_rfd_adr_o;
        wb_result_o  <= (ctrl_op_o[OP_LOAD] | ctrl_op_o[OP_MFSPR]) ? ctrl_ack_data_i
                                                                   : ctrl_result_o;
      end
    end
  end

endmodule
